// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the pipelined datapath: iterative MULT/MULTU (shift-add) and
// DIV/DIVU (restoring), one bit per cycle, plus MTHI/MTLO writes and hazard stall.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             read_hilo,
    input  logic             write_hi,
    input  logic             write_lo,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               op_div;
    logic               sign_a;
    logic               sign_b;
    logic               b_zero;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;

    // Operand capture: op[0]=1 selects the unsigned variants.
    logic               a_neg_in;
    logic               b_neg_in;
    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;

    always_comb begin
        a_neg_in = ~op[0] & a[WIDTH-1];
        b_neg_in = ~op[0] & b[WIDTH-1];
        a_mag_in = a_neg_in ? -a : a;
        b_mag_in = b_neg_in ? -b : b;
    end

    // One iteration of each algorithm. Multiply accumulates in the upper half
    // and shifts product bits down; divide keeps remainder high, quotient low.
    logic [CNT_W-1:0]   idx;
    logic [WIDTH:0]     mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        idx       = LAST - cnt;
        mul_add   = b_q[cnt] ? {1'b0, a_q} : '0;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + mul_add;
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], a_q[idx]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ok    = ~div_diff[WIDTH];
        rem_next  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_next  = {rem_next, acc[WIDTH-2:0], div_ok};
    end

    // Sign fix-up and divide-by-zero override applied when results are written.
    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        hi_res   = prod_fix[2*WIDTH-1:WIDTH];
        lo_res   = prod_fix[WIDTH-1:0];
        if (op_div) begin
            if (b_zero) begin
                hi_res = sign_a ? -a_q : a_q;
                lo_res = '1;
            end else begin
                hi_res = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                lo_res = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == S_FINISH);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_div <= op[1];
                        sign_a <= a_neg_in;
                        sign_b <= b_neg_in;
                        a_q    <= a_mag_in;
                        b_q    <= b_mag_in;
                        b_zero <= (b == '0);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end else begin
                        if (write_hi) hi <= write_data;
                        if (write_lo) lo <= write_data;
                    end
                end
                S_RUN: begin
                    acc <= op_div ? div_next : mul_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) state <= S_FINISH;
                end
                S_FINISH: begin
                    hi    <= hi_res;
                    lo    <= lo_res;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        stall     = busy & (start | read_hilo | write_hi | write_lo);
        state_dbg = state;
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: latency, results, hazards, MTLO and reset abort.
module tb_hilo_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        read_hilo;
    logic        write_hi;
    logic        write_lo;
    logic [31:0] write_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .read_hilo  (read_hilo),
        .write_hi   (write_hi),
        .write_lo   (write_lo),
        .write_data (write_data),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .stall      (stall),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_operands();
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        b  = $urandom;
    endtask

    // Issue one operation and follow it to its Done pulse.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp, input string tag);
        int nb;
        bit seen;
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_operands();
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_busy_cycles"}, 64'(nb), 64'd33);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_hilo"}, {hi, lo}, exp);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int nb;
        int ndone;
        bit seen;
        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        read_hilo = 1'b0; write_hi = 1'b0; write_lo = 1'b0; write_data = '0;

        #2;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
        run_op(OP_MULT,  32'hFFFF_FFF9, 32'd6,         64'hFFFF_FFFF_FFFF_FFD6, "mult_neg");
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_minmin");
        run_op(OP_DIV,   32'hFFFF_FFEF, 32'd5,         64'hFFFF_FFFE_FFFF_FFFD, "div_neg");
        run_op(OP_DIVU,  32'd17,        32'd5,         64'h0000_0002_0000_0003, "divu_small");
        run_op(OP_DIVU,  32'h0000_1234, 32'd0,         64'h0000_1234_FFFF_FFFF, "divu_zero");
        run_op(OP_DIV,   32'hFFFF_FF00, 32'd0,         64'hFFFF_FF00_FFFF_FFFF, "div_zero_neg");
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf");
        run_op(OP_DIVU,  32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, "divu_by_one");
        run_op(OP_MULTU, 32'd3,         32'd5,         64'h0000_0000_0000_000F, "multu_small");

        // Hazards while busy: start a DIVU, then pile up requests mid-flight.
        @(negedge clk);
        op = OP_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_operands();
        repeat (4) @(negedge clk);
        read_hilo = 1'b1; write_hi = 1'b1; write_data = 32'hDEAD_BEEF;
        start = 1'b1; op = OP_MULTU; a = 32'd100; b = 32'd7;
        #1;
        check("hz_stall_first", 64'(stall), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            check("hz_stall", 64'(stall), 64'd1);
            check("hz_hilo_hold", {hi, lo}, 64'h0000_0000_0000_000F);
        end
        check("hz_done_seen", 64'(seen), 64'd1);
        check("hz_first_result", {hi, lo}, 64'h0000_0006_0000_008E);
        check("hz_stall_done_cycle", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0; read_hilo = 1'b0; write_hi = 1'b0;
        scramble_operands();
        @(negedge clk);
        check("hz_second_accepted", 64'(busy), 64'd1);
        check("hz_write_dropped", 64'(hi), 64'h0000_0006);
        seen = 1'b0;
        nb = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
        end
        check("hz_second_done", 64'(seen), 64'd1);
        check("hz_second_busy", 64'(nb), 64'd33);
        check("hz_second_result", {hi, lo}, 64'h0000_0000_0000_02BC);

        // MTLO / MTHI in IDLE take effect at the next edge with no stall.
        @(negedge clk);
        write_lo = 1'b1; write_data = 32'hA5A5_A5A5;
        #1;
        check("mtlo_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        write_lo = 1'b0;
        @(negedge clk);
        check("mtlo_lo", 64'(lo), 64'hA5A5_A5A5);
        check("mtlo_hi_kept", 64'(hi), 64'd0);
        write_hi = 1'b1; write_data = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        write_hi = 1'b0;
        @(negedge clk);
        check("mthi_hilo", {hi, lo}, 64'h1357_9BDF_A5A5_A5A5);

        // Reset mid-MULT aborts immediately and never pulses Done.
        @(negedge clk);
        op = OP_MULT; a = 32'h0001_2345; b = 32'h10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        check("abort_idle_hilo", {hi, lo}, 64'd0);
        run_op(OP_MULT, 32'd1000, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_F448, "post_reset_mult");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
